// File: rtl/riscV_unrn_pkg.sv
// Shared types and constants for the trap sequencer: FSM state encoding,
// synchronous exception cause codes and the machine-timer interrupt cause.
package riscV_unrn_pkg;

    typedef logic [1:0] trap_state_t;

    localparam trap_state_t ST_RUN   = 2'd0;
    localparam trap_state_t ST_TRAP  = 2'd1;
    localparam trap_state_t ST_MRET  = 2'd2;
    localparam trap_state_t ST_SLEEP = 2'd3;

    localparam logic [31:0] EXC_FETCH_MISAL = 32'd0;
    localparam logic [31:0] EXC_ILLEGAL     = 32'd2;
    localparam logic [31:0] EXC_EBREAK      = 32'd3;
    localparam logic [31:0] EXC_LOAD_MISAL  = 32'd4;
    localparam logic [31:0] EXC_STORE_MISAL = 32'd6;
    localparam logic [31:0] EXC_ECALL       = 32'd11;

    localparam logic [31:0] MCAUSE_MTIMER_INT = 32'h8000_0007;

    // Direct-mode trap vector: the low two mtvec bits carry the mode field.
    function automatic logic [31:0] align_vec(input logic [31:0] base);
        return {base[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Execute-stage / CSR-unit bundle seen by the trap sequencer.
// The core side uses the master modport, the sequencer the slave modport.
interface trap_sequencer_if;
    logic        instr_valid_i;
    logic [31:0] pc_i;
    logic        exc_fetch_misal_i;
    logic        exc_illegal_i;
    logic        exc_ecall_i;
    logic        exc_ebreak_i;
    logic        exc_load_misal_i;
    logic        exc_store_misal_i;
    logic [31:0] fault_addr_i;
    logic [31:0] instr_bits_i;
    logic        mret_i;
    logic        wfi_i;
    logic        mtime_irq_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;

    logic        jumpingToMtvec_o;
    logic [31:0] excCause_o;
    logic [31:0] trapInfo_o;
    logic [31:0] trap_pc_o;
    logic        mret_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        kill_o;
    logic        stall_o;

    modport master (
        output instr_valid_i, pc_i,
        output exc_fetch_misal_i, exc_illegal_i, exc_ecall_i,
        output exc_ebreak_i, exc_load_misal_i, exc_store_misal_i,
        output fault_addr_i, instr_bits_i, mret_i, wfi_i, mtime_irq_i,
        output mtvec_i, mepc_i,
        input  jumpingToMtvec_o, excCause_o, trapInfo_o, trap_pc_o,
        input  mret_o, redirect_o, redirect_pc_o, kill_o, stall_o
    );

    modport slave (
        input  instr_valid_i, pc_i,
        input  exc_fetch_misal_i, exc_illegal_i, exc_ecall_i,
        input  exc_ebreak_i, exc_load_misal_i, exc_store_misal_i,
        input  fault_addr_i, instr_bits_i, mret_i, wfi_i, mtime_irq_i,
        input  mtvec_i, mepc_i,
        output jumpingToMtvec_o, excCause_o, trapInfo_o, trap_pc_o,
        output mret_o, redirect_o, redirect_pc_o, kill_o, stall_o
    );
endinterface

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder for synchronous exceptions: picks the
// winning mcause and the matching mtval from the raw execute-stage flags.
import riscV_unrn_pkg::*;

module trap_prio_enc (
    input  logic        fetch_misal,
    input  logic        illegal,
    input  logic        ebreak,
    input  logic        ecall,
    input  logic        load_misal,
    input  logic        store_misal,
    input  logic [31:0] pc,
    input  logic [31:0] fault_addr,
    input  logic [31:0] instr_bits,
    output logic        any_sync,
    output logic [31:0] cause,
    output logic [31:0] info
);

    // Fixed priority chain, highest first; ecall reports no trap value.
    always_comb begin
        any_sync = 1'b1;
        cause    = 32'd0;
        info     = 32'd0;
        if (fetch_misal) begin
            cause = EXC_FETCH_MISAL;
            info  = fault_addr;
        end else if (illegal) begin
            cause = EXC_ILLEGAL;
            info  = instr_bits;
        end else if (ebreak) begin
            cause = EXC_EBREAK;
            info  = pc;
        end else if (ecall) begin
            cause = EXC_ECALL;
            info  = 32'd0;
        end else if (load_misal) begin
            cause = EXC_LOAD_MISAL;
            info  = fault_addr;
        end else if (store_misal) begin
            cause = EXC_STORE_MISAL;
            info  = fault_addr;
        end else begin
            any_sync = 1'b0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: exception/interrupt entry, MRET and WFI sleep.
// Define TRAP_WFI_EN to enable WFI and the SLEEP state; otherwise wfi_i is a NOP.
import riscV_unrn_pkg::*;

module trap_sequencer (
    input  logic             clk,
    input  logic             rst_n,
    trap_sequencer_if.slave  tif
);

    trap_state_t state_r;
    trap_state_t state_nxt_s;
    logic        ready_r;

    logic        any_sync_s;
    logic [31:0] prio_cause_s;
    logic [31:0] prio_info_s;
    logic        kill_s;

    logic [31:0] cause_nxt_s;
    logic [31:0] info_nxt_s;
    logic [31:0] tpc_nxt_s;

    logic        jump_r;
    logic        mret_r;
    logic        redirect_r;
    logic        stall_r;
    logic [31:0] cause_r;
    logic [31:0] info_r;
    logic [31:0] tpc_r;
    logic [31:0] rpc_r;

`ifdef TRAP_WFI_EN
    logic [31:0] wake_pc_r;
    logic [31:0] wake_pc_nxt_s;
`endif

    trap_prio_enc u_prio (
        .fetch_misal (tif.exc_fetch_misal_i),
        .illegal     (tif.exc_illegal_i),
        .ebreak      (tif.exc_ebreak_i),
        .ecall       (tif.exc_ecall_i),
        .load_misal  (tif.exc_load_misal_i),
        .store_misal (tif.exc_store_misal_i),
        .pc          (tif.pc_i),
        .fault_addr  (tif.fault_addr_i),
        .instr_bits  (tif.instr_bits_i),
        .any_sync    (any_sync_s),
        .cause       (prio_cause_s),
        .info        (prio_info_s)
    );

    // ready_r holds off trap entry until one edge after reset release.
    assign kill_s = ready_r && (state_r == ST_RUN) && tif.instr_valid_i &&
                    (any_sync_s || tif.mtime_irq_i);

    // Next-state and trap-payload selection.
    always_comb begin
        state_nxt_s = state_r;
        cause_nxt_s = 32'd0;
        info_nxt_s  = 32'd0;
        tpc_nxt_s   = 32'd0;
`ifdef TRAP_WFI_EN
        wake_pc_nxt_s = wake_pc_r;
`endif
        case (state_r)
            ST_RUN: begin
                if (ready_r && tif.instr_valid_i) begin
                    if (any_sync_s) begin
                        state_nxt_s = ST_TRAP;
                        cause_nxt_s = prio_cause_s;
                        info_nxt_s  = prio_info_s;
                        tpc_nxt_s   = tif.pc_i;
                    end else if (tif.mtime_irq_i) begin
                        state_nxt_s = ST_TRAP;
                        cause_nxt_s = MCAUSE_MTIMER_INT;
                        tpc_nxt_s   = tif.pc_i;
                    end else if (tif.mret_i) begin
                        state_nxt_s = ST_MRET;
`ifdef TRAP_WFI_EN
                    end else if (tif.wfi_i) begin
                        state_nxt_s   = ST_SLEEP;
                        wake_pc_nxt_s = tif.pc_i + 32'd4;
`endif
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_TRAP: state_nxt_s = ST_RUN;
            ST_MRET: state_nxt_s = ST_RUN;
`ifdef TRAP_WFI_EN
            ST_SLEEP: begin
                if (tif.mtime_irq_i) begin
                    state_nxt_s = ST_TRAP;
                    cause_nxt_s = MCAUSE_MTIMER_INT;
                    tpc_nxt_s   = wake_pc_r;
                end else begin
                    state_nxt_s = ST_SLEEP;
                end
            end
`endif
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State and output registers; outputs are decoded from the next state so
    // each strobe lines up with the cycle spent in TRAP or MRET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            ready_r    <= 1'b0;
            jump_r     <= 1'b0;
            mret_r     <= 1'b0;
            redirect_r <= 1'b0;
            stall_r    <= 1'b0;
            cause_r    <= 32'd0;
            info_r     <= 32'd0;
            tpc_r      <= 32'd0;
            rpc_r      <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            ready_r    <= 1'b1;
            jump_r     <= (state_nxt_s == ST_TRAP);
            mret_r     <= (state_nxt_s == ST_MRET);
            redirect_r <= (state_nxt_s == ST_TRAP) || (state_nxt_s == ST_MRET);
            stall_r    <= (state_nxt_s != ST_RUN);
            if (state_nxt_s == ST_TRAP) begin
                cause_r <= cause_nxt_s;
                info_r  <= info_nxt_s;
                tpc_r   <= tpc_nxt_s;
                rpc_r   <= align_vec(tif.mtvec_i);
            end else if (state_nxt_s == ST_MRET) begin
                cause_r <= 32'd0;
                info_r  <= 32'd0;
                tpc_r   <= 32'd0;
                rpc_r   <= tif.mepc_i;
            end else begin
                cause_r <= 32'd0;
                info_r  <= 32'd0;
                tpc_r   <= 32'd0;
                rpc_r   <= 32'd0;
            end
        end
    end

`ifdef TRAP_WFI_EN
    // Return address captured when WFI retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake_pc_r <= 32'd0;
        end else begin
            wake_pc_r <= wake_pc_nxt_s;
        end
    end
`endif

    assign tif.jumpingToMtvec_o = jump_r;
    assign tif.excCause_o       = cause_r;
    assign tif.trapInfo_o       = info_r;
    assign tif.trap_pc_o        = tpc_r;
    assign tif.mret_o           = mret_r;
    assign tif.redirect_o       = redirect_r;
    assign tif.redirect_pc_o    = rpc_r;
    assign tif.kill_o           = kill_s;
    assign tif.stall_o          = stall_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: behavioural model compared every
// cycle plus directed vectors with literal expectations.
`timescale 1ns/1ps

module tb_trap_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    trap_sequencer_if tif ();

    trap_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam logic [31:0] INT_CAUSE = 32'h8000_0007;
    int unsigned cause_tab [6] = '{0, 2, 3, 11, 4, 6};

    bit          m_ready = 1'b0;
    bit          m_sleep = 1'b0;
    logic [31:0] m_wake  = 32'd0;
    logic        e_jump  = 1'b0;
    logic        e_mret  = 1'b0;
    logic [31:0] e_cause = 32'd0;
    logic [31:0] e_info  = 32'd0;
    logic [31:0] e_tpc   = 32'd0;
    logic [31:0] e_rpc   = 32'd0;

    function automatic logic [5:0] sync_flags();
        return {tif.exc_fetch_misal_i, tif.exc_illegal_i, tif.exc_ebreak_i,
                tif.exc_ecall_i, tif.exc_load_misal_i, tif.exc_store_misal_i};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ready = 1'b0; m_sleep = 1'b0; m_wake = 32'd0;
            e_jump = 1'b0; e_mret = 1'b0;
            e_cause = 32'd0; e_info = 32'd0; e_tpc = 32'd0; e_rpc = 32'd0;
        end else begin
            bit busy;
            logic [5:0] f;
            busy   = e_jump || e_mret;
            e_jump = 1'b0;
            e_mret = 1'b0;
            f      = sync_flags();
            if (!m_ready) begin
                m_ready = 1'b1;
            end else if (busy) begin
                m_ready = 1'b1;
            end else if (m_sleep) begin
                if (tif.mtime_irq_i) begin
                    m_sleep = 1'b0;
                    e_jump = 1'b1; e_cause = INT_CAUSE; e_info = 32'd0; e_tpc = m_wake;
                    e_rpc = tif.mtvec_i & 32'hFFFF_FFFC;
                end
            end else if (tif.instr_valid_i) begin
                if (f != 6'd0) begin
                    int k;
                    k = 0;
                    while (!f[5-k]) k++;
                    e_jump  = 1'b1;
                    e_cause = cause_tab[k];
                    case (cause_tab[k])
                        2:       e_info = tif.instr_bits_i;
                        3:       e_info = tif.pc_i;
                        11:      e_info = 32'd0;
                        default: e_info = tif.fault_addr_i;
                    endcase
                    e_tpc = tif.pc_i;
                    e_rpc = tif.mtvec_i & 32'hFFFF_FFFC;
                end else if (tif.mtime_irq_i) begin
                    e_jump = 1'b1; e_cause = INT_CAUSE; e_info = 32'd0; e_tpc = tif.pc_i;
                    e_rpc = tif.mtvec_i & 32'hFFFF_FFFC;
                end else if (tif.mret_i) begin
                    e_mret = 1'b1; e_rpc = tif.mepc_i;
`ifdef TRAP_WFI_EN
                end else if (tif.wfi_i) begin
                    m_sleep = 1'b1; m_wake = tif.pc_i + 32'd4;
`endif
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic e_kill;
        e_kill = rst_n && m_ready && !e_jump && !e_mret && !m_sleep &&
                 tif.instr_valid_i && ((sync_flags() != 6'd0) || tif.mtime_irq_i);
        chk("kill", {31'd0, tif.kill_o}, {31'd0, e_kill});
        chk("jump", {31'd0, tif.jumpingToMtvec_o}, {31'd0, e_jump});
        chk("mret", {31'd0, tif.mret_o}, {31'd0, e_mret});
        chk("redirect", {31'd0, tif.redirect_o}, {31'd0, e_jump || e_mret});
        chk("stall", {31'd0, tif.stall_o}, {31'd0, e_jump || e_mret || m_sleep});
        if (e_jump) begin
            chk("cause", tif.excCause_o, e_cause);
            chk("info", tif.trapInfo_o, e_info);
            chk("trap_pc", tif.trap_pc_o, e_tpc);
        end
        if (e_jump || e_mret) chk("redirect_pc", tif.redirect_pc_o, e_rpc);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tif.instr_valid_i = 1'b0;
        tif.exc_fetch_misal_i = 1'b0; tif.exc_illegal_i = 1'b0;
        tif.exc_ebreak_i = 1'b0;      tif.exc_ecall_i = 1'b0;
        tif.exc_load_misal_i = 1'b0;  tif.exc_store_misal_i = 1'b0;
        tif.mret_i = 1'b0; tif.wfi_i = 1'b0; tif.mtime_irq_i = 1'b0;
    endtask

    task automatic set_flags(input logic [5:0] f);
        {tif.exc_fetch_misal_i, tif.exc_illegal_i, tif.exc_ebreak_i,
         tif.exc_ecall_i, tif.exc_load_misal_i, tif.exc_store_misal_i} = f;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_jump"}, {31'd0, tif.jumpingToMtvec_o}, 32'd0);
        chk({nm, "_mret"}, {31'd0, tif.mret_o}, 32'd0);
        chk({nm, "_redirect"}, {31'd0, tif.redirect_o}, 32'd0);
        chk({nm, "_stall"}, {31'd0, tif.stall_o}, 32'd0);
        chk({nm, "_kill"}, {31'd0, tif.kill_o}, 32'd0);
        chk({nm, "_cause"}, tif.excCause_o, 32'd0);
        chk({nm, "_rpc"}, tif.redirect_pc_o, 32'd0);
    endtask

    // {flags, irq, mret, wfi}
    logic [8:0] vec_tab [9] = '{
        9'b111111_0_0_0, 9'b011100_1_0_0, 9'b001100_0_1_0,
        9'b000110_0_0_1, 9'b000011_0_0_0, 9'b000001_1_0_0,
        9'b000000_1_1_1, 9'b000100_0_1_0, 9'b100000_0_0_0
    };

    initial begin
        int stall_cnt;
        idle();
        tif.pc_i = 32'd0; tif.fault_addr_i = 32'd0; tif.instr_bits_i = 32'd0;
        tif.mtvec_i = 32'h0000_0200; tif.mepc_i = 32'h0000_0340;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk_quiet("reset");
        rst_n = 1'b1;

        // Illegal instruction, offered already in the first cycle after release.
        tif.instr_valid_i = 1'b1; tif.exc_illegal_i = 1'b1;
        tif.pc_i = 32'h0000_0100; tif.instr_bits_i = 32'hFFFF_FFFF;
        step();
        chk("first_edge_no_strobe", {31'd0, tif.jumpingToMtvec_o}, 32'd0);
        #2;
        chk("ill_kill", {31'd0, tif.kill_o}, 32'd1);
        step();
        idle();
        chk("ill_jump", {31'd0, tif.jumpingToMtvec_o}, 32'd1);
        chk("ill_cause", tif.excCause_o, 32'd2);
        chk("ill_info", tif.trapInfo_o, 32'hFFFF_FFFF);
        chk("ill_tpc", tif.trap_pc_o, 32'h0000_0100);
        chk("ill_rpc", tif.redirect_pc_o, 32'h0000_0200);
        chk("ill_stall", {31'd0, tif.stall_o}, 32'd1);
        step();

        // Load misaligned together with a timer interrupt.
        tif.instr_valid_i = 1'b1; tif.exc_load_misal_i = 1'b1; tif.mtime_irq_i = 1'b1;
        tif.pc_i = 32'h0000_0400; tif.fault_addr_i = 32'h0000_1003;
        step();
        chk("ld_cause", tif.excCause_o, 32'd4);
        chk("ld_info", tif.trapInfo_o, 32'h0000_1003);
        tif.exc_load_misal_i = 1'b0; tif.pc_i = 32'h0000_0404;
        #2;
        chk("trap_cycle_no_kill", {31'd0, tif.kill_o}, 32'd0);
        step();
        chk("no_back_to_back", {31'd0, tif.jumpingToMtvec_o}, 32'd0);
        step();
        idle();
        chk("irq_cause", tif.excCause_o, 32'h8000_0007);
        chk("irq_info", tif.trapInfo_o, 32'd0);
        chk("irq_tpc", tif.trap_pc_o, 32'h0000_0404);
        step();

        // MRET.
        tif.instr_valid_i = 1'b1; tif.mret_i = 1'b1; tif.pc_i = 32'h0000_0500;
        step();
        idle();
        chk("mret_strobe", {31'd0, tif.mret_o}, 32'd1);
        chk("mret_rpc", tif.redirect_pc_o, 32'h0000_0340);
        chk("mret_no_jump", {31'd0, tif.jumpingToMtvec_o}, 32'd0);
        step();
        chk("mret_one_cycle", {31'd0, tif.mret_o}, 32'd0);

        // Priority and arbitration table; each vector followed by an idle cycle.
        for (int i = 0; i < 9; i++) begin
            tif.instr_valid_i = 1'b1;
            set_flags(vec_tab[i][8:3]);
            tif.mtime_irq_i = vec_tab[i][2];
            tif.mret_i = vec_tab[i][1];
            tif.wfi_i = 1'b0;
            tif.pc_i = 32'h0000_1000 + 32'(i) * 32'd4;
            tif.fault_addr_i = 32'h0000_A000 + 32'(i);
            tif.instr_bits_i = 32'hC0DE_0000 + 32'(i);
            step();
            idle();
            step();
        end

        // Flags without instr_valid_i start nothing.
        set_flags(6'b111111); tif.mtime_irq_i = 1'b1; tif.mret_i = 1'b1; tif.wfi_i = 1'b1;
        #2;
        chk("novalid_kill", {31'd0, tif.kill_o}, 32'd0);
        step();
        chk("novalid_jump", {31'd0, tif.jumpingToMtvec_o}, 32'd0);
        chk("novalid_stall", {31'd0, tif.stall_o}, 32'd0);
        idle();

        // Mode bits of mtvec are dropped from the redirect target.
        tif.mtvec_i = 32'h0000_0203;
        tif.instr_valid_i = 1'b1; tif.exc_ecall_i = 1'b1; tif.pc_i = 32'h0000_0600;
        step();
        idle();
        chk("mtvec_align", tif.redirect_pc_o, 32'h0000_0200);
        chk("ecall_cause", tif.excCause_o, 32'd11);
        tif.mtvec_i = 32'h0000_0200;
        step();

        // WFI, then a timer interrupt ten cycles later.
        tif.instr_valid_i = 1'b1; tif.wfi_i = 1'b1; tif.pc_i = 32'h0000_01FC;
        step();
        idle();
        stall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (tif.stall_o) stall_cnt++;
            step();
        end
        tif.mtime_irq_i = 1'b1;
        step();
        idle();
`ifdef TRAP_WFI_EN
        chk("wfi_stall_cycles", 32'(stall_cnt), 32'd10);
        chk("wfi_jump", {31'd0, tif.jumpingToMtvec_o}, 32'd1);
        chk("wfi_tpc", tif.trap_pc_o, 32'h0000_0200);
        chk("wfi_cause", tif.excCause_o, 32'h8000_0007);
`else
        chk("wfi_stall_cycles", 32'(stall_cnt), 32'd0);
        chk("wfi_jump", {31'd0, tif.jumpingToMtvec_o}, 32'd0);
`endif
        step();

        // Reset asserted during the TRAP cycle.
        tif.instr_valid_i = 1'b1; tif.exc_store_misal_i = 1'b1;
        tif.pc_i = 32'h0000_0700; tif.fault_addr_i = 32'h0000_2002;
        step();
        idle();
        chk("pre_rst_jump", {31'd0, tif.jumpingToMtvec_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        #10;
        rst_n = 1'b1;
        repeat (4) step();
        chk_quiet("post_rst");

        // One ordinary trap after the reset to show recovery.
        tif.instr_valid_i = 1'b1; tif.exc_ebreak_i = 1'b1; tif.pc_i = 32'h0000_0800;
        step();
        idle();
        chk("ebreak_info", tif.trapInfo_o, 32'h0000_0800);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset. The ports are listed below, clock and reset first.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr_valid_i  in  1  instruction in execute is valid and at a retire boundary this cycle.
REQ-005 pc_i  in  32  PC of the instruction in execute.
REQ-006 exc_fetch_misal_i, exc_illegal_i, exc_ecall_i, exc_ebreak_i, exc_load_misal_i, exc_store_misal_i  in  1 each  synchronous exception flags, qualified by instr_valid_i.
REQ-007 fault_addr_i  in  32  faulting fetch/load/store address.
REQ-008 instr_bits_i  in  32  raw instruction word, used for the illegal-instruction trap value.
REQ-009 mret_i, wfi_i  in  1 each  decoded MRET / WFI in execute.
REQ-010 mtime_irq_i  in  1  enabled, pending timer interrupt from the CSR unit.
REQ-011 mtvec_i, mepc_i  in  32 each  trap vector base and saved PC from the CSR unit.
REQ-012 jumpingToMtvec_o  out  1  one-cycle trap-entry strobe to the CSR unit.
REQ-013 excCause_o, trapInfo_o, trap_pc_o  out  32 each  mcause, mtval and mepc values, valid while jumpingToMtvec_o=1.
REQ-014 mret_o  out  1  one-cycle strobe to restore mstatus.MIE.
REQ-015 redirect_o  out  1  fetch redirect strobe; redirect_pc_o  out  32  redirect target.
REQ-016 kill_o  out  1  combinational; suppresses writeback of the instruction in execute.
REQ-017 stall_o  out  1  freezes the fetch and execute pipeline.

Function
REQ-018 FSM states SHALL be RUN, TRAP, MRET, SLEEP; the reset state is RUN.
REQ-019 In RUN with instr_valid_i=1 and any sync flag set: kill_o=1 in the same cycle; next state TRAP; cause, info and pc are registered.
REQ-020 Sync priority SHALL be, highest first: fetch_misal(0), illegal(2), ebreak(3), ecall(11), load_misal(4), store_misal(6).
REQ-021 trapInfo_o SHALL be fault_addr_i for misaligned causes, instr_bits_i for illegal, pc_i for ebreak, and 0 for ecall.
REQ-022 In RUN with instr_valid_i=1, no sync flag, and mtime_irq_i=1: kill_o=1; cause 0x8000_0007; info 0; trap_pc_o=pc_i; next state TRAP.
REQ-023 Sync exceptions SHALL win over the interrupt; both SHALL win over mret_i/wfi_i in the same cycle.
REQ-024 TRAP (exactly 1 cycle): jumpingToMtvec_o=1, redirect_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}, stall_o=1; then RUN.
REQ-025 In RUN with mret_i=1 and no trap: next state MRET. MRET (1 cycle): mret_o=1, redirect_o=1, redirect_pc_o=mepc_i, stall_o=1; then RUN.
REQ-026 In RUN with wfi_i=1 and no trap: next state SLEEP (WFI retires, not killed); the PC is latched as pc_i+4 (mod 2^32).
REQ-027 SLEEP: stall_o=1. On mtime_irq_i=1: cause 0x8000_0007, trap_pc_o=latched pc_i+4, next state TRAP.
REQ-028 instr_valid_i=0 SHALL never start a trap, MRET or SLEEP.
REQ-029 All outputs except kill_o SHALL be registered or state-decoded; there are no back-to-back traps without an intervening RUN cycle.

Reset
REQ-030 Assertion of rst_n=0 in any state, including mid-TRAP or SLEEP, SHALL force RUN and all outputs and registers to 0 immediately.
REQ-031 After deassertion, the first trap strobe SHALL be possible no earlier than the second rising edge.

Configuration
REQ-032 With TRAP_WFI_EN defined, WFI and the SLEEP state SHALL behave per REQ-026/027.
REQ-033 Without TRAP_WFI_EN, wfi_i SHALL be ignored (NOP) and SLEEP unreachable/absent.

Structure
REQ-034 riscV_unrn_pkg SHALL hold trap_state_t, the EXC_* cause constants and MCAUSE_MTIMER_INT (0x8000_0007).
REQ-035 One combinational sub-module, trap_prio_enc, SHALL select cause and info from the flags; the FSM stays in trap_sequencer.

Verification
REQ-036 illegal_i=1, pc_i=0x100, instr=0xFFFF_FFFF, mtvec=0x200 -> kill same cycle; next cycle strobe, cause 2, info 0xFFFF_FFFF, trap_pc 0x100, redirect 0x200.
REQ-037 load_misal_i and mtime_irq_i both set, addr 0x1003 -> cause 4, info 0x1003; the interrupt is taken on a later boundary as 0x8000_0007.
REQ-038 mret_i=1, mepc=0x340 -> mret_o and redirect to 0x340 for exactly 1 cycle, no jumpingToMtvec_o.
REQ-039 With TRAP_WFI_EN: wfi at pc 0x1FC; irq 10 cycles later -> stall held 10 cycles; trap_pc 0x200, cause 0x8000_0007. Without TRAP_WFI_EN: no stall.
REQ-040 rst_n low during the TRAP cycle -> all outputs 0 asynchronously; RUN after release; no residual strobe.
REQ-041 Flags with instr_valid_i=0 -> no kill, no strobe; mtvec=0x203 -> redirect 0x200.
